fifo_ptr_ctrl: RTL and testbench

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

---
 rtl/fifo_ptr_ctrl_pkg.sv | 14 +
 rtl/fifo_ptr_cnt.sv | 29 ++
 rtl/fifo_ptr_ctrl.sv | 96 +++++++++
 tb/tb_fifo_ptr_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared FIFO definitions: default geometry used by the pointer controller and
// the memory block it drives, plus pointer-bank indices.
package fifo_ptr_ctrl_pkg;

  localparam int ADDRESS_SIZE_DEF = 2;
  localparam int MEMORY_WIDTH_DEF = 8;
  localparam int MEMORY_DEPTH_DEF = 1 << ADDRESS_SIZE_DEF;

  // Index of each pointer inside the controller's counter bank.
  localparam int PTR_WR  = 0;
  localparam int PTR_RD  = 1;
  localparam int NUM_PTR = 2;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping pointer counter: advances by one on each clock where inc is high,
// rolling over naturally at 2**WIDTH.
module fifo_ptr_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q + WIDTH'(inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer controller: qualifies producer/consumer requests against the
// full/empty state, owns both wrap-bit pointers and reports status/errors.
module fifo_ptr_ctrl
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int ADDRESS_SIZE  = ADDRESS_SIZE_DEF,
  parameter int MEMORY_DEPTH  = MEMORY_DEPTH_DEF,
  parameter int AFULL_MARGIN  = 1,
  parameter int AEMPTY_MARGIN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic                  clr_err,
  output logic                  cw_en,
  output logic                  cr_en,
  output logic [ADDRESS_SIZE:0] w_ptr,
  output logic [ADDRESS_SIZE:0] r_ptr,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDRESS_SIZE:0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ADDRESS_SIZE + 1;
  localparam logic [PW-1:0] AFULL_TH  = PW'(MEMORY_DEPTH - AFULL_MARGIN);
  localparam logic [PW-1:0] AEMPTY_TH = PW'(AEMPTY_MARGIN);

  logic [PW-1:0]      ptr [NUM_PTR];
  logic [NUM_PTR-1:0] inc;

  logic rvalid_q, rvalid_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign inc[PTR_WR] = cw_en;
  assign inc[PTR_RD] = cr_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PTR; gi++) begin : g_ptr
      fifo_ptr_cnt #(
        .WIDTH (PW)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc[gi]),
        .ptr   (ptr[gi])
      );
    end
  endgenerate

  assign w_ptr = ptr[PTR_WR];
  assign r_ptr = ptr[PTR_RD];

  // Status is purely a function of the registered pointers, so it is glitch-free
  // relative to the requests and correct while reset holds the pointers at zero.
  always_comb begin
    empty        = (w_ptr == r_ptr);
    full         = (w_ptr[PW-1] != r_ptr[PW-1]) && (w_ptr[PW-2:0] == r_ptr[PW-2:0]);
    count        = w_ptr - r_ptr;
    almost_full  = (count >= AFULL_TH);
    almost_empty = (count <= AEMPTY_TH);
    cw_en        = w_en & ~full;
    cr_en        = r_en & ~empty;
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    rvalid_d    = cr_en;
    overflow_d  = (w_en & full)  | (overflow_q  & ~clr_err);
    underflow_d = (r_en & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: queue-based occupancy model with an attached memory,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_ptr_ctrl;

  localparam int AS = 2;
  localparam int D  = 4;
  localparam int PW = AS + 1;

  logic          clk;
  logic          rst_n;
  logic          w_en, r_en, clr_err;
  logic          cw_en, cr_en;
  logic [PW-1:0] w_ptr, r_ptr, count;
  logic          rvalid, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [7:0]    wdata;

  fifo_ptr_ctrl #(
    .ADDRESS_SIZE  (AS),
    .MEMORY_DEPTH  (D),
    .AFULL_MARGIN  (1),
    .AEMPTY_MARGIN (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w_en         (w_en),
    .r_en         (r_en),
    .clr_err      (clr_err),
    .cw_en        (cw_en),
    .cr_en        (cr_en),
    .w_ptr        (w_ptr),
    .r_ptr        (r_ptr),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory attached to the controller's strobes and pointers, one-cycle read.
  logic [7:0] mem [D];
  logic [7:0] rdata;
  always @(posedge clk) begin
    if (cw_en) mem[w_ptr[AS-1:0]] <= wdata;
    if (cr_en) rdata <= mem[r_ptr[AS-1:0]];
  end

  // Reference model: FIFO contents as a queue, pointers as running totals.
  byte unsigned q[$];
  int  wtot, rtot;
  bit  m_ov, m_un, m_rv;
  byte unsigned m_rd;

  always @(posedge clk or negedge rst_n) begin : model_p
    bit f, e, dw, dr;
    if (!rst_n) begin
      q.delete();
      wtot = 0;
      rtot = 0;
      m_ov = 0;
      m_un = 0;
      m_rv = 0;
    end else begin
      f  = (q.size() == D);
      e  = (q.size() == 0);
      dw = w_en && !f;
      dr = r_en && !e;
      m_ov = (w_en && f) || (m_ov && !clr_err);
      m_un = (r_en && e) || (m_un && !clr_err);
      m_rv = dr;
      if (dr) m_rd = q.pop_front();
      if (dw) q.push_back(wdata);
      wtot = (wtot + int'(dw)) % (2 * D);
      rtot = (rtot + int'(dr)) % (2 * D);
    end
  end

  always @(negedge clk) begin : cmp_p
    int n;
    n = q.size();
    chk("cw_en",        cw_en,        w_en && (n != D));
    chk("cr_en",        cr_en,        r_en && (n != 0));
    chk("count",        count,        n);
    chk("full",         full,         n == D);
    chk("empty",        empty,        n == 0);
    chk("almost_full",  almost_full,  n >= D - 1);
    chk("almost_empty", almost_empty, n <= 1);
    chk("w_ptr",        w_ptr,        wtot);
    chk("r_ptr",        r_ptr,        rtot);
    chk("rvalid",       rvalid,       m_rv);
    chk("overflow",     overflow,     m_ov);
    chk("underflow",    underflow,    m_un);
    if (m_rv) chk("rdata", rdata, m_rd);
  end

  task automatic cyc(input bit w, input bit r, input bit c);
    @(posedge clk);
    #1;
    w_en    = w;
    r_en    = r;
    clr_err = c;
    wdata   = 8'($urandom);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_empty",  empty, 1);
    chk("rst_count",  count, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull",  almost_full, 0);
    chk("rst_full",   full, 0);
    chk("rst_cw_en",  cw_en, 0);
    chk("rst_cr_en",  cr_en, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fill to full, then an overflowing write and its clear.
    for (int i = 0; i < D; i++) begin
      cyc(1, 0, 0);
      chk("fill_count", count, i);
      if (i == 3) chk("fill_afull3", almost_full, 1);
      else        chk("fill_afull",  almost_full, 0);
    end
    cyc(0, 0, 0);
    chk("full_count", count, 4);
    chk("full_flag",  full, 1);
    chk("full_wptr",  w_ptr, 3'b100);
    cyc(1, 0, 0);
    chk("ovf_cw_en", cw_en, 0);
    cyc(0, 0, 0);
    chk("ovf_set",  overflow, 1);
    chk("ovf_wptr", w_ptr, 3'b100);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("ovf_clr", overflow, 0);

    // Drain, then an underflowing read.
    for (int i = 0; i < D; i++) begin
      cyc(0, 1, 0);
      chk("drain_cr_en", cr_en, 1);
    end
    cyc(0, 0, 0);
    chk("drain_empty",  empty, 1);
    chk("drain_rvalid", rvalid, 1);
    cyc(0, 1, 0);
    chk("unf_cr_en", cr_en, 0);
    cyc(0, 0, 0);
    chk("unf_set",    underflow, 1);
    chk("unf_rvalid", rvalid, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("unf_clr", underflow, 0);

    // Two more fill/drain rounds: pointers wrap through 3'b111 -> 3'b000.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < D; i++) cyc(1, 0, 0);
      for (int i = 0; i < D; i++) cyc(0, 1, 0);
    end
    cyc(0, 0, 0);
    chk("wrap_wptr", w_ptr, 3'b100);
    chk("wrap_rptr", r_ptr, 3'b100);

    // Simultaneous traffic at count 2, at full and at empty.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("both_count", count, 2);
    chk("both_wptr",  w_ptr, 3'b011);
    chk("both_rptr",  r_ptr, 3'b001);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("full_rw_count", count, 3);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 1);
    chk("empty_rw_count", count, 1);

    // Randomized traffic, write-biased then read-biased.
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35,
                        $urandom_range(0, 99) < 5);
      else          cyc($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70,
                        $urandom_range(0, 99) < 5);
    end

    // Reset in the middle of a write burst at count 3.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    cyc(0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("mid_count", count, 3);
    #2;
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    #1;
    chk("mid_rst_empty",  empty, 1);
    chk("mid_rst_count",  count, 0);
    chk("mid_rst_wptr",   w_ptr, 0);
    chk("mid_rst_rptr",   r_ptr, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_ovf",    overflow, 0);
    chk("mid_rst_unf",    underflow, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
